// File: rtl/sobel_pkg.sv
// Shared types, widths and gradient helpers for the raster-scan Sobel stage.
package sobel_pkg;

    localparam int unsigned GRAD_W  = 11;
    localparam int unsigned MAG_W   = 12;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned SAT_LIM = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Weighted column/row sum a + 2b + c; max 1020 fits the gradient width.
    function automatic logic [GRAD_W-1:0] col_sum(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b,
                                                  input logic [PIX_W-1:0] c);
        return GRAD_W'(a) + GRAD_W'({b, 1'b0}) + GRAD_W'(c);
    endfunction

    // Magnitude of a two's-complement gradient, widened to the magnitude width.
    function automatic logic [MAG_W-1:0] abs_grad(input logic [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] neg;
        neg = GRAD_W'(0) - g;
        return g[GRAD_W-1] ? MAG_W'(neg) : MAG_W'(g);
    endfunction

endpackage

// File: rtl/sobel_bram_scan_if.sv
// Frame control, input-RAM read port and output-RAM write port of the Sobel stage.
interface sobel_bram_scan_if;

    logic                             start;
    logic                             busy;
    logic                             done;
    logic [sobel_pkg::ADDR_W-1:0]     ram_addr;
    logic [sobel_pkg::PIX_W-1:0]      ram_dout;
    logic                             out_valid;
    logic [sobel_pkg::ADDR_W-1:0]     out_addr;
    logic [sobel_pkg::PIX_W-1:0]      out_data;

    modport master (
        input  start, ram_dout,
        output busy, done, ram_addr, out_valid, out_addr, out_data
    );

    modport slave (
        output start, ram_dout,
        input  busy, done, ram_addr, out_valid, out_addr, out_data
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// Fixed-depth pixel shift register; dout is the pixel pushed DEPTH shifts ago.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [DEPTH-1:0][PIX_W-1:0] mem;

    // Contents are never cleared; frame validity gating hides stale data.
    always_ff @(posedge clk) begin
        if (en) begin
            mem <= {mem[DEPTH-2:0], din};
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_bram_scan.sv
// Raster-scan Sobel edge stage between an input and an output block RAM.
// Optional build macro SOBEL_THRESH_EN: binarise the magnitude against THRESH.
module sobel_bram_scan
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned THRESH = 128
) (
    input  logic              clk,
    input  logic              rst,
    sobel_bram_scan_if.master bus
);

    localparam int unsigned       N_PIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST    = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

    state_t state, state_nxt;
    logic   drain_cnt;
    logic   accept_c, scan_c;

    logic [ADDR_W-1:0] ram_addr, rd_addr, win_addr, out_addr;
    logic [ADDR_W-1:0] x, y;
    logic              rd_vld, win_vld, win_last;
    logic              busy, done, out_valid;
    logic [PIX_W-1:0]  out_data;

    logic [PIX_W-1:0]            lb1_out, lb2_out;
    logic [2:0][2:0][PIX_W-1:0]  win;
    logic [GRAD_W-1:0]           gx_c, gy_c;
    logic [MAG_W-1:0]            mag_c;
    logic [PIX_W-1:0]            pix_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SCAN;
            SCAN:    if (ram_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept_c = 1'b0;
        scan_c   = 1'b0;
        case (state)
            IDLE:    accept_c = bus.start;
            SCAN:    scan_c   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // Address generation, arrival tracking and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            rd_addr   <= '0;
            rd_vld    <= 1'b0;
            x         <= '0;
            y         <= '0;
            win_vld   <= 1'b0;
            win_last  <= 1'b0;
            win_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            rd_vld  <= scan_c;
            rd_addr <= ram_addr;

            if (accept_c) begin
                ram_addr <= '0;
            end else if (scan_c && ram_addr != LAST_ADDR) begin
                ram_addr <= ram_addr + ADDR_W'(1);
            end

            if (accept_c) begin
                x <= '0;
                y <= '0;
            end else if (rd_vld) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + ADDR_W'(1);
                end else begin
                    x <= x + ADDR_W'(1);
                end
            end

            win_vld   <= rd_vld && (x >= TWO) && (y >= TWO);
            win_last  <= rd_vld && (x == X_LAST) && (y == Y_LAST);
            win_addr  <= rd_addr - CTR_OFS;

            out_valid <= win_vld;
            done      <= win_last;
            if (win_vld) begin
                out_addr <= win_addr;
                out_data <= pix_c;
            end

            if (accept_c) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_W)) lb1 (
        .clk  (clk),
        .en   (rd_vld),
        .din  (bus.ram_dout),
        .dout (lb1_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_W)) lb2 (
        .clk  (clk),
        .en   (rd_vld),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Window rows: 0 = y-2, 1 = y-1, 2 = y; column 2 is the newest pixel.
    always_ff @(posedge clk) begin
        if (rd_vld) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_out;
            win[1][2] <= lb1_out;
            win[2][2] <= bus.ram_dout;
        end
    end

    always_comb begin
        gx_c  = col_sum(win[0][2], win[1][2], win[2][2]) - col_sum(win[0][0], win[1][0], win[2][0]);
        gy_c  = col_sum(win[2][0], win[2][1], win[2][2]) - col_sum(win[0][0], win[0][1], win[0][2]);
        mag_c = abs_grad(gx_c) + abs_grad(gy_c);
    end

`ifdef SOBEL_THRESH_EN
    assign pix_c = (mag_c >= MAG_W'(THRESH)) ? 8'hFF : 8'h00;
`else
    assign pix_c = (mag_c > MAG_W'(SAT_LIM)) ? PIX_W'(SAT_LIM) : mag_c[PIX_W-1:0];
`endif

    assign bus.ram_addr  = ram_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_sobel_bram_scan.sv
// Self-checking bench for sobel_bram_scan against a direct 3x3 Sobel reference.
module tb_sobel_bram_scan;

    localparam int IMG_W   = 64;
    localparam int IMG_H   = 64;
    localparam int THRESH  = 128;
    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int EXP_CNT = (IMG_W - 2) * (IMG_H - 2);
    localparam int TIMEOUT = 6000;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] img [N_PIX];

    int checks = 0;
    int errors = 0;
    int q_addr[$];
    int q_data[$];

    sobel_bram_scan_if bus ();

    sobel_bram_scan #(.IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Input RAM with one cycle of registered read latency.
    always @(posedge clk) bus.ram_dout <= img[bus.ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_img(input int kind);
        for (int k = 0; k < N_PIX; k++) begin
            int xx;
            xx = k % IMG_W;
            case (kind)
                0:       img[k] = 8'h40;
                1:       img[k] = (xx < 32) ? 8'd0 : 8'd255;
                2:       img[k] = 8'(4 * xx);
                default: img[k] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    function automatic int px(input int xx, input int yy);
        return int'(img[yy * IMG_W + xx]);
    endfunction

    // Expected edge pixel for the window centred on (xx, yy).
    function automatic int model_pix(input int xx, input int yy);
        int gx, gy, mag;
        gx = (px(xx+1, yy-1) + 2*px(xx+1, yy) + px(xx+1, yy+1))
           - (px(xx-1, yy-1) + 2*px(xx-1, yy) + px(xx-1, yy+1));
        gy = (px(xx-1, yy+1) + 2*px(xx, yy+1) + px(xx+1, yy+1))
           - (px(xx-1, yy-1) + 2*px(xx, yy-1) + px(xx+1, yy-1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= THRESH) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    task automatic run_frame(input string tag, input bit mid_start);
        int  i, t130, tfirst, tlast, tdone, bad, first_bad;
        bit  done_seen, done_v;
        q_addr.delete();
        q_data.delete();
        t130 = -1; tfirst = -1; tlast = -1; tdone = -2;
        done_seen = 1'b0; done_v = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        i = 0;
        while (!done_seen && i < TIMEOUT) begin
            if (bus.busy === 1'b1 && bus.ram_addr === 13'd130 && t130 < 0) t130 = i;
            if (bus.out_valid === 1'b1) begin
                q_addr.push_back(int'(bus.out_addr));
                q_data.push_back(int'(bus.out_data));
                if (tfirst < 0) tfirst = i;
                tlast = i;
            end
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                tdone     = i;
                done_v    = bus.out_valid;
            end
            bus.start = mid_start && (i == 2000);
            i++;
            if (!done_seen) @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        @(negedge clk);
        check({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
        check({tag, " out_count"}, 32'(q_addr.size()), 32'(EXP_CNT));
        check({tag, " first_addr"}, (q_addr.size() > 0) ? 32'(q_addr[0]) : 32'hFFFF_FFFF, 32'(IMG_W + 1));
        check({tag, " last_addr"}, (q_addr.size() > 0) ? 32'(q_addr[q_addr.size()-1]) : 32'hFFFF_FFFF,
              32'((IMG_H - 2) * IMG_W + IMG_W - 2));
        check({tag, " latency"}, 32'(tfirst - t130), 32'd3);
        check({tag, " done_with_last"}, 32'(tdone), 32'(tlast));
        check({tag, " done_valid"}, 32'(done_v), 32'd1);
        bad = 0; first_bad = -1; i = 0;
        for (int yy = 1; yy < IMG_H - 1; yy++) begin
            for (int xx = 1; xx < IMG_W - 1; xx++) begin
                if (i >= q_addr.size() || q_addr[i] != yy * IMG_W + xx || q_data[i] != model_pix(xx, yy)) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
                i++;
            end
        end
        check($sformatf("%s stream_bad_pixels(first_idx=%0d)", tag, first_bad), 32'(bad), 32'd0);
    endtask

    initial begin
        int i;
        rst       = 1'b1;
        bus.start = 1'b0;
        load_img(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst out_addr", 32'(bus.out_addr), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);

        run_frame("uniform", 1'b0);
        load_img(1);
        run_frame("vstep", 1'b0);
        load_img(2);
        run_frame("ramp", 1'b0);
        load_img(3);
        run_frame("random", 1'b0);
        run_frame("random_midstart", 1'b1);

        // Abort a frame with reset at address 1000, then run a clean frame.
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        i = 0;
        while (bus.ram_addr !== 13'd1000 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("reach_addr_1000", 32'(bus.ram_addr), 32'd1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ram_addr", 32'(bus.ram_addr), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("abort out_valid_%0d", k), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        load_img(3);
        run_frame("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
